asciiram_reader: RTL

Read-side sequencer for the 80-column ASCII text RAM: the CPU writes characters into the RAM at {row, col} addresses, and this block reads them back in raster order for the glyph renderer. On each frame start it walks every text row, every font scanline within that row, and every column. It issues synchronous reads and streams each returned character code, tagged with its row, scanline and column, over a valid/ready interface. It sits between the ASCII RAM read port and the VGA glyph renderer.

---
 rtl/asciiram_reader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/asciiram_reader.sv
// rtl/asciiram_reader.sv - raster-order read sequencer for the ASCII text RAM
//
// Walks every text row, every font scanline within it, and every column once
// per frame_start, reading the character RAM and streaming tagged characters
// to the glyph renderer through a 2-entry output buffer.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   frame_start           pulse requesting one frame walk
//   ram_rd_en, ram_addr   RAM read strobe and {row, col} address
//   ram_rdata             character code, valid the cycle after ram_rd_en
//   out_valid/out_ready   output handshake
//   out_char/row/line/col character and its position tags
//   out_last              final element of the frame
//   busy                  walk in progress
//   frame_done            pulse when the out_last element is accepted
//   frame_overrun         sticky: frame_start seen while busy
module asciiram_reader #(
    parameter int ROW_BIT  = 5,
    parameter int COL_BIT  = 7,
    parameter int ROW_NUM  = 30,
    parameter int COL_NUM  = 80,
    parameter int LINE_BIT = 4,
    parameter int FONT_H   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    output logic                       ram_rd_en,
    output logic [ROW_BIT+COL_BIT-1:0] ram_addr,
    input  logic [7:0]                 ram_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_char,
    output logic [ROW_BIT-1:0]         out_row,
    output logic [LINE_BIT-1:0]        out_line,
    output logic [COL_BIT-1:0]         out_col,
    output logic                       out_last,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       frame_overrun
);

    localparam int TAG_W = ROW_BIT + LINE_BIT + COL_BIT + 1;
    localparam int ENT_W = 8 + TAG_W;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              state_q;
    logic [ROW_BIT-1:0]  row_q, row_d;
    logic [LINE_BIT-1:0] line_q, line_d;
    logic [COL_BIT-1:0]  col_q, col_d;
    logic                inflight_q;
    logic [TAG_W-1:0]    tag_q;
    logic [ENT_W-1:0]    ent0_q, ent1_q;   // ent0_q is the buffer head
    logic [1:0]          count_q;
    logic                overrun_q;

    logic                col_wrap, line_wrap, row_wrap, at_last;
    logic                pop, push, rd_en;
    logic [1:0]          occ;
    logic [ENT_W-1:0]    push_data;

    assign col_wrap  = (col_q == COL_BIT'(COL_NUM - 1));
    assign line_wrap = (line_q == LINE_BIT'(FONT_H - 1));
    assign row_wrap  = (row_q == ROW_BIT'(ROW_NUM - 1));
    assign at_last   = col_wrap && line_wrap && row_wrap;

    always_comb begin
        col_d  = col_wrap ? '0 : col_q + COL_BIT'(1);
        line_d = line_q;
        row_d  = row_q;
        if (col_wrap) begin
            line_d = line_wrap ? '0 : line_q + LINE_BIT'(1);
            if (line_wrap) begin
                row_d = row_wrap ? '0 : row_q + ROW_BIT'(1);
            end
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && out_ready;
    // The read issued last cycle returns data now and lands in the buffer.
    assign push      = inflight_q;
    assign push_data = {ram_rdata, tag_q};

    // Never allow more than two elements to be buffered or in flight; a pop
    // this cycle frees a slot early so back-to-back reads can continue.
    assign occ   = count_q + {1'b0, inflight_q};
    assign rd_en = (state_q == FETCH) && ((occ < 2'd2) || ((occ == 2'd2) && pop));

    assign ram_rd_en     = rd_en;
    assign ram_addr      = {row_q, col_q};
    assign {out_char, out_row, out_line, out_col, out_last} = ent0_q;
    assign busy          = (state_q != IDLE);
    assign frame_done    = pop && out_last;
    assign frame_overrun = overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            line_q     <= '0;
            col_q      <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            count_q    <= 2'd0;
            overrun_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        state_q <= FETCH;
                        row_q   <= '0;
                        line_q  <= '0;
                        col_q   <= '0;
                    end
                end
                FETCH: begin
                    if (rd_en) begin
                        row_q  <= row_d;
                        line_q <= line_d;
                        col_q  <= col_d;
                        if (at_last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (frame_start && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end

            inflight_q <= rd_en;
            if (rd_en) begin
                tag_q <= {row_q, line_q, col_q, at_last};
            end

            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent0_q <= push_data;
                    end else begin
                        ent1_q <= push_data;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    ent0_q  <= ent1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_q <= push_data;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
